// File: rtl/branch_resolver.sv
// branch_resolver
//   Checks the IF-stage direction predictions against the EX-stage outcome.
//   Predictions are queued in fetch order. Each resolving instruction pops the
//   queue head and is compared with it. A mispredict, or a head/PC mismatch,
//   produces a one-cycle registered flush and a redirect PC, followed by one
//   FLUSH cycle that empties the queue. Every resolved branch or jump emits a
//   registered BHT update.
//
// Optional feature (compile-time macro BRANCH_PERF_CNT_EN):
//   Adds the saturating 32-bit counters perf_branches and perf_mispred.
//
// Parameters
//   DEPTH  prediction queue entries (power of 2, >= 2)
//   IDX_W  BHT index width; upd_index = ex_pc[IDX_W-1:0]
//
// Ports
//   clk, rst_n                  clock; asynchronous active-low reset
//   if_valid/if_pc/if_pred      prediction issued by fetch
//   ex_valid/ex_pc/ex_branch/
//   ex_jump/ex_br_en/ex_target  resolution from EX; ex_valid pops the queue
//   q_full                      queue full, fetch must stall (combinational)
//   flush/redirect_pc           registered squash pulse and restart PC
//   upd_valid/upd_index/
//   upd_taken                   registered BHT update
//   sync_err                    sticky queue/EX desynchronisation flag
//   perf_branches/perf_mispred  event counters (only with BRANCH_PERF_CNT_EN)
module branch_resolver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_pred,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             ex_br_en,
  input  logic [31:0]      ex_target,
  output logic             q_full,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_index,
  output logic             upd_taken,
  output logic             sync_err
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispred
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]      pc_mem_q [DEPTH];
  logic [DEPTH-1:0] pred_mem_q;

  logic             flush_q, flush_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0] upd_index_q, upd_index_d;
  logic             upd_taken_q, upd_taken_d;
  logic             sync_err_q, sync_err_d;

  // ---------------------------------------------------------------------------
  // Queue status
  // ---------------------------------------------------------------------------
  logic             in_run;
  logic             q_empty;
  logic             q_full_w;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic [31:0]      head_pc;
  logic             head_pred;

  assign in_run   = (state_q == ST_RUN);
  assign wr_idx   = wr_ptr_q[PTR_W-1:0];
  assign rd_idx   = rd_ptr_q[PTR_W-1:0];
  assign q_empty  = (wr_ptr_q == rd_ptr_q);
  // Same slot, different lap: the writer is exactly DEPTH entries ahead.
  assign q_full_w = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
  assign q_full   = q_full_w;

  assign head_pc   = pc_mem_q[rd_idx];
  assign head_pred = pred_mem_q[rd_idx];

  // Everything arriving while in FLUSH is wrong-path and ignored.
  assign pop  = in_run && ex_valid && !q_empty;
  // A pop in the same cycle frees the slot the push needs, so a full queue
  // still accepts a push when it is also being popped.
  assign push = in_run && if_valid && (!q_full_w || pop);

  // ---------------------------------------------------------------------------
  // Resolution
  // ---------------------------------------------------------------------------
  logic        is_ctrl;
  logic        actual;
  logic        resolve;
  logic        sync_bad;
  logic        mispredict;
  logic [31:0] pc_plus4;
  logic [31:0] restart_pc;

  assign is_ctrl  = ex_branch | ex_jump;
  assign actual   = ex_jump | (ex_branch & ex_br_en);
  assign resolve  = in_run && ex_valid;
  // head_pc is stale when the queue is empty; q_empty alone flags that case.
  assign sync_bad = q_empty || (ex_pc != head_pc);
  // A desync forces a redirect so fetch restarts from a known-good PC.
  assign mispredict = resolve && (sync_bad || (is_ctrl && (actual != head_pred)));
  assign pc_plus4   = ex_pc + 32'd4;
  assign restart_pc = actual ? ex_target : pc_plus4;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (mispredict) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (!in_run) begin
      // Every queued entry is younger than the mispredicted instruction.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
    end
  end

  always_comb begin
    flush_d       = mispredict;
    redirect_pc_d = redirect_pc_q;
    upd_valid_d   = resolve && is_ctrl;
    upd_index_d   = upd_index_q;
    upd_taken_d   = upd_taken_q;
    sync_err_d    = sync_err_q;
    if (mispredict) redirect_pc_d = restart_pc;
    if (resolve && is_ctrl) begin
      upd_index_d = ex_pc[IDX_W-1:0];
      upd_taken_d = actual;
    end
    if (resolve && sync_bad) sync_err_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_index_q   <= '0;
      upd_taken_q   <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      upd_valid_q   <= upd_valid_d;
      upd_index_q   <= upd_index_d;
      upd_taken_q   <= upd_taken_d;
      sync_err_q    <= sync_err_d;
    end
  end

  // Queue storage; only the slot at the write pointer changes on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pc_mem_q[i] <= '0;
      pred_mem_q <= '0;
    end else if (push) begin
      pc_mem_q[wr_idx]   <= if_pc;
      pred_mem_q[wr_idx] <= if_pred;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign upd_valid   = upd_valid_q;
  assign upd_index   = upd_index_q;
  assign upd_taken   = upd_taken_q;
  assign sync_err    = sync_err_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;

  // Counted off the registered strobes, so they trail the events by a cycle.
  always_comb begin
    perf_branches_d = perf_branches_q;
    perf_mispred_d  = perf_mispred_q;
    if (upd_valid_q && (perf_branches_q != 32'hFFFF_FFFF)) begin
      perf_branches_d = perf_branches_q + 32'd1;
    end
    if (flush_q && (perf_mispred_q != 32'hFFFF_FFFF)) begin
      perf_mispred_d = perf_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_q <= '0;
      perf_mispred_q  <= '0;
    end else begin
      perf_branches_q <= perf_branches_d;
      perf_mispred_q  <= perf_mispred_d;
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_mispred  = perf_mispred_q;
`endif

endmodule
